skip_sched: RTL

- Pattern scheduler for the clock-skip ring; it configures and sequences it.
- Holds a small table of (MASK, rSEL, dwell) entries and steps the ring through them in order.
- It presents each pattern to the ring, pulses the ring's reload, and gates E.
- It counts ring revolutions through the ring's bit-0 output and advances to the next entry when an entry's dwell expires.
- It sits between the board-level control logic and the skipring instance.

---
 rtl/skip_pkg.sv | 31 +++
 rtl/skip_sched_if.sv | 32 +++
 rtl/skip_tbl.sv | 33 +++
 rtl/skip_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/skip_pkg.sv
// Shared constants, FSM state encoding and table entry layout for the
// clock-skip ring pattern scheduler.
package skip_pkg;

    localparam int LEN   = 16;  // ring length, width of MASK / rSEL
    localparam int DEPTH = 4;   // pattern table entries (power of 2)
    localparam int AW    = 2;   // table address width
    localparam int DWW   = 8;   // dwell counter width, in ring revolutions

    // Reload select driven out of reset and whenever the scheduler is idle.
    localparam logic [LEN-1:0] DEF_SEL = {{(LEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    typedef struct packed {
        logic [LEN-1:0] mask;
        logic [LEN-1:0] sel;
        logic [DWW-1:0] dwell;   // 0 marks the end of the list
    } entry_t;

    // Next table index; DEPTH is a power of 2 so the carry-out is the wrap.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/skip_sched_if.sv
// Control, table-write and ring-side signals of the skip scheduler.
// master = board control / ring side, slave = the scheduler itself.
interface skip_sched_if;
    import skip_pkg::*;

    logic           START;
    logic           STOP;
    logic           WE;
    logic [AW-1:0]  WADDR;
    logic [LEN-1:0] WMASK;
    logic [LEN-1:0] WSEL;
    logic [DWW-1:0] WDWELL;
    logic           RING_B0;

    logic [LEN-1:0] rSEL;
    logic [LEN-1:0] MASK;
    logic           E;
    logic           LOAD;
    logic           BUSY;
    logic [AW-1:0]  IDX;

    modport master (
        output START, STOP, WE, WADDR, WMASK, WSEL, WDWELL, RING_B0,
        input  rSEL, MASK, E, LOAD, BUSY, IDX
    );

    modport slave (
        input  START, STOP, WE, WADDR, WMASK, WSEL, WDWELL, RING_B0,
        output rSEL, MASK, E, LOAD, BUSY, IDX
    );

endinterface

// File: rtl/skip_tbl.sv
// Pattern table: DEPTH entries, one synchronous write port, one
// combinational read port, plus a fixed tap on entry 0 (start check and
// end-of-list wrap target). Cleared to all zero on RST.
module skip_tbl
    import skip_pkg::*;
(
    input  logic          iCLK,
    input  logic          RST,
    input  logic          WE,
    input  logic [AW-1:0] WADDR,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata,
    output entry_t        ent0
);

    entry_t mem [DEPTH];

    // Register file write, with synchronous clear so every dwell reads 0.
    always_ff @(posedge iCLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WE) begin
            mem[WADDR] <= wdata;
        end
    end

    assign rdata = mem[raddr];
    assign ent0  = mem[0];

endmodule

// File: rtl/skip_sched.sv
// Clock-skip ring pattern scheduler. Steps the ring through the table
// entries, presenting MASK/rSEL with a one-cycle reload pulse, and counts
// ring revolutions (rising edges of the ring's bit 0) to time each dwell.
module skip_sched
    import skip_pkg::*;
(
    input  logic         iCLK,
    input  logic         RST,
    skip_sched_if.slave  bus
);

    state_e         state, nxt_state;
    logic [AW-1:0]  idx_r, nxt_idx;
    logic [DWW-1:0] dcnt, nxt_dcnt;
    logic [LEN-1:0] mask_r, nxt_mask;
    logic [LEN-1:0] sel_r, nxt_sel;
    logic           stop_pend, nxt_stop_pend;
    logic           e_r, load_r, busy_r;
    logic           b0_q, b0_rise;
    logic           stop_any;

    entry_t         wr_ent, rd_ent, ent0, tgt;
    logic [AW-1:0]  rd_addr, tgt_idx;

    assign wr_ent = {bus.WMASK, bus.WSEL, bus.WDWELL};

    skip_tbl u_tbl (
        .iCLK  (iCLK),
        .RST   (RST),
        .WE    (bus.WE),
        .WADDR (bus.WADDR),
        .wdata (wr_ent),
        .raddr (rd_addr),
        .rdata (rd_ent),
        .ent0  (ent0)
    );

    // The read port always looks one entry ahead; a zero dwell there is the
    // end-of-list marker, which sends the sequence back to entry 0.
    assign rd_addr  = wrap_inc(idx_r);
    assign tgt      = (rd_ent.dwell != '0) ? rd_ent : ent0;
    assign tgt_idx  = (rd_ent.dwell != '0) ? rd_addr : '0;

    assign b0_rise  = bus.RING_B0 & ~b0_q;
    assign stop_any = bus.STOP | stop_pend;

    // Next-state and next-output decode; every output is registered from it.
    always_comb begin
        nxt_state     = state;
        nxt_idx       = idx_r;
        nxt_dcnt      = dcnt;
        nxt_mask      = mask_r;
        nxt_sel       = sel_r;
        nxt_stop_pend = stop_pend;

        case (state)
            ST_IDLE: begin
                nxt_stop_pend = 1'b0;
                if (bus.START && !bus.STOP && (ent0.dwell != '0)) begin
                    nxt_state = ST_LOAD;
                    nxt_idx   = '0;
                    nxt_mask  = ent0.mask;
                    nxt_sel   = ent0.sel;
                    nxt_dcnt  = ent0.dwell;
                end
            end

            ST_LOAD: begin
                // A STOP pulse during the reload cycle must not be lost.
                if (bus.STOP) nxt_stop_pend = 1'b1;
                nxt_state = ST_RUN;
            end

            ST_RUN: begin
                if (bus.STOP) nxt_stop_pend = 1'b1;
                if (b0_rise) begin
                    nxt_dcnt = dcnt - 1'b1;
                    if (stop_any) begin
                        // Stop on a revolution boundary: no need to wait.
                        nxt_state = ST_IDLE;
                    end else if (dcnt == DWW'(1)) begin
                        if (tgt.dwell == '0) begin
                            // Table emptied under us: finish one more lap.
                            nxt_state = ST_HALT;
                        end else begin
                            nxt_state = ST_LOAD;
                            nxt_idx   = tgt_idx;
                            nxt_mask  = tgt.mask;
                            nxt_sel   = tgt.sel;
                            nxt_dcnt  = tgt.dwell;
                        end
                    end
                end else if (stop_any) begin
                    nxt_state = ST_HALT;
                end
            end

            ST_HALT: begin
                if (b0_rise) nxt_state = ST_IDLE;
            end

            default: nxt_state = ST_IDLE;
        endcase

        if (nxt_state == ST_IDLE) nxt_sel = DEF_SEL;
    end

    // State, counters and registered outputs.
    always_ff @(posedge iCLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            idx_r     <= '0;
            dcnt      <= '0;
            mask_r    <= '0;
            sel_r     <= DEF_SEL;
            stop_pend <= 1'b0;
            e_r       <= 1'b0;
            load_r    <= 1'b0;
            busy_r    <= 1'b0;
            b0_q      <= 1'b0;
        end else begin
            state     <= nxt_state;
            idx_r     <= nxt_idx;
            dcnt      <= nxt_dcnt;
            mask_r    <= nxt_mask;
            sel_r     <= nxt_sel;
            stop_pend <= nxt_stop_pend;
            e_r       <= (nxt_state == ST_RUN) || (nxt_state == ST_HALT);
            load_r    <= (nxt_state == ST_LOAD);
            busy_r    <= (nxt_state != ST_IDLE);
            b0_q      <= bus.RING_B0;
        end
    end

    assign bus.rSEL = sel_r;
    assign bus.MASK = mask_r;
    assign bus.E    = e_r;
    assign bus.LOAD = load_r;
    assign bus.BUSY = busy_r;
    assign bus.IDX  = idx_r;

endmodule
